// File: rtl/tile_check.sv
// Trax legal-move checker: scans the six tile placements against the latched neighbour edges.
// Optional TILE_CHECK_FIRST_MOVE_EN: an all-empty neighbourhood makes every placement legal.
module tile_check #(
  parameter int unsigned NUM_TILES = 6
) (
  output logic [NUM_TILES-1:0] tile_type,
  output logic                 endsignal,
  input  logic                 start_signal,
  input  logic [2:0]           up_tile,
  input  logic [2:0]           down_tile,
  input  logic [2:0]           right_tile,
  input  logic [2:0]           left_tile,
  input  logic                 clk,
  input  logic                 rst
);

  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

  state_t                 state_q, state_d;
  logic [2:0]             index_q;
  logic [2:0]             up_q, down_q, right_q, left_q;
  logic [NUM_TILES-1:0]   mask_q;
  logic                   end_q;

  // Edge colours packed as {up, down, left, right}, 1 = red.
  function automatic logic [3:0] tile_edges(input logic [2:0] code);
    case (code)
      3'd1:    tile_edges = 4'b1100;
      3'd2:    tile_edges = 4'b0011;
      3'd3:    tile_edges = 4'b1010;
      3'd4:    tile_edges = 4'b1001;
      3'd5:    tile_edges = 4'b0101;
      3'd6:    tile_edges = 4'b0110;
      default: tile_edges = 4'b0000;
    endcase
  endfunction

  logic [3:0] cand_e, up_e, down_e, left_e, right_e;
  logic       any_occupied, any_invalid, edges_ok, cand_legal;

  always_comb begin
    cand_e  = tile_edges(index_q);
    up_e    = tile_edges(up_q);
    down_e  = tile_edges(down_q);
    left_e  = tile_edges(left_q);
    right_e = tile_edges(right_q);

    any_occupied = (up_q != 3'd0) || (down_q != 3'd0) || (left_q != 3'd0) || (right_q != 3'd0);
    any_invalid  = (up_q == 3'd7) || (down_q == 3'd7) || (left_q == 3'd7) || (right_q == 3'd7);

    // Each candidate edge faces the opposite edge of the neighbour on that side.
    edges_ok = ((up_q    == 3'd0) || (cand_e[3] == up_e[2]))    &&
               ((down_q  == 3'd0) || (cand_e[2] == down_e[3]))  &&
               ((left_q  == 3'd0) || (cand_e[1] == left_e[0]))  &&
               ((right_q == 3'd0) || (cand_e[0] == right_e[1]));

`ifdef TILE_CHECK_FIRST_MOVE_EN
    cand_legal = !any_occupied || (!any_invalid && edges_ok);
`else
    cand_legal = any_occupied && !any_invalid && edges_ok;
`endif
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start_signal) state_d = SCAN;
      SCAN:    if (index_q == 3'(NUM_TILES)) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      index_q <= 3'd1;
      up_q    <= '0;
      down_q  <= '0;
      right_q <= '0;
      left_q  <= '0;
      mask_q  <= '0;
      end_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      // Registered strobe: rises one edge after the last candidate is written.
      end_q   <= (state_q == DONE);
      case (state_q)
        IDLE: begin
          if (start_signal) begin
            up_q    <= up_tile;
            down_q  <= down_tile;
            right_q <= right_tile;
            left_q  <= left_tile;
            mask_q  <= '0;
            index_q <= 3'd1;
          end
        end
        SCAN: begin
          mask_q[index_q - 3'd1] <= cand_legal;
          index_q                <= index_q + 3'd1;
        end
        DONE:    index_q <= 3'd1;
        default: index_q <= 3'd1;
      endcase
    end
  end

  assign tile_type = mask_q;
  assign endsignal = end_q;

endmodule

// File: tb/tb_tile_check.sv
// Directed self-checking bench for tile_check: legality masks, latency, reset abort, start handling.
module tb_tile_check;

  logic       clk = 1'b0;
  logic       rst;
  logic [5:0] tile_type;
  logic       endsignal;
  logic       start_signal;
  logic [2:0] up_tile, down_tile, right_tile, left_tile;

  int checks   = 0;
  int failures = 0;

  tile_check dut (
    .tile_type    (tile_type),
    .endsignal    (endsignal),
    .start_signal (start_signal),
    .up_tile      (up_tile),
    .down_tile    (down_tile),
    .right_tile   (right_tile),
    .left_tile    (left_tile),
    .clk          (clk),
    .rst          (rst)
  );

  always #5 clk = ~clk;

  task automatic set_inputs(input logic [2:0] u, input logic [2:0] d,
                            input logic [2:0] l, input logic [2:0] r);
    up_tile = u; down_tile = d; left_tile = l; right_tile = r;
  endtask

  // Pulse start for one edge, then check latency, mask, strobe width and hold.
  task automatic do_scan(input logic [2:0] u, input logic [2:0] d,
                         input logic [2:0] l, input logic [2:0] r,
                         input logic [5:0] exp, input string nm);
    int lat;
    @(negedge clk);
    set_inputs(u, d, l, r);
    start_signal = 1'b1;
    @(posedge clk); #1;
    start_signal = 1'b0;
    checks++;
    if (tile_type !== 6'b0) begin
      failures++;
      $display("FAIL %s_clear: tile_type=%b required=000000", nm, tile_type);
    end
    lat = 0;
    while (endsignal !== 1'b1 && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    checks++;
    if (lat !== 7) begin
      failures++;
      $display("FAIL %s_latency: edges=%0d required=7", nm, lat);
    end
    checks++;
    if (tile_type !== exp) begin
      failures++;
      $display("FAIL %s_mask: tile_type=%b required=%b", nm, tile_type, exp);
    end
    @(posedge clk); #1;
    checks++;
    if (endsignal !== 1'b0) begin
      failures++;
      $display("FAIL %s_strobe_width: endsignal=%b required=0", nm, endsignal);
    end
    checks++;
    if (tile_type !== exp) begin
      failures++;
      $display("FAIL %s_hold: tile_type=%b required=%b", nm, tile_type, exp);
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    start_signal = 1'b0;
    set_inputs(3'd0, 3'd0, 3'd0, 3'd0);
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (tile_type !== 6'b0 || endsignal !== 1'b0) begin
      failures++;
      $display("FAIL reset_state: tile_type=%b endsignal=%b required=000000/0", tile_type, endsignal);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_masks;
    do_scan(3'd1, 3'd0, 3'd0, 3'd0, 6'b001101, "up1");
    do_scan(3'd1, 3'd2, 3'd0, 3'd0, 6'b001100, "up1_down2");
    do_scan(3'd0, 3'd0, 3'd3, 3'd6, 6'b011000, "left3_right6");
    do_scan(3'd0, 3'd0, 3'd0, 3'd2, 6'b011010, "right2");
    do_scan(3'd7, 3'd0, 3'd0, 3'd0, 6'b000000, "up7");
    do_scan(3'd1, 3'd0, 3'd0, 3'd7, 6'b000000, "right7");
  endtask

  task automatic test_all_empty;
`ifdef TILE_CHECK_FIRST_MOVE_EN
    do_scan(3'd0, 3'd0, 3'd0, 3'd0, 6'b111111, "all_empty");
`else
    do_scan(3'd0, 3'd0, 3'd0, 3'd0, 6'b000000, "all_empty");
`endif
  endtask

  task automatic test_reset_midscan;
    int ends;
    do_scan(3'd1, 3'd0, 3'd0, 3'd0, 6'b001101, "pre_abort");
    @(negedge clk);
    set_inputs(3'd0, 3'd5, 3'd0, 3'd0);
    start_signal = 1'b1;
    @(posedge clk); #1;
    start_signal = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (tile_type !== 6'b0 || endsignal !== 1'b0) begin
      failures++;
      $display("FAIL abort_reset: tile_type=%b endsignal=%b required=000000/0", tile_type, endsignal);
    end
    @(negedge clk);
    rst = 1'b0;
    ends = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      if (endsignal === 1'b1) ends++;
    end
    checks++;
    if (ends !== 0) begin
      failures++;
      $display("FAIL abort_no_end: endsignal pulses=%0d required=0", ends);
    end
    do_scan(3'd0, 3'd5, 3'd0, 3'd0, 6'b001110, "after_abort");
  endtask

  task automatic test_start_during_scan;
    int ends;
    @(negedge clk);
    set_inputs(3'd1, 3'd0, 3'd0, 3'd0);
    start_signal = 1'b1;
    @(posedge clk); #1;
    start_signal = 1'b0;
    @(posedge clk);
    @(negedge clk);
    set_inputs(3'd7, 3'd2, 3'd3, 3'd6);
    start_signal = 1'b1;
    @(negedge clk);
    start_signal = 1'b0;
    ends = 0;
    for (int i = 0; i < 16; i++) begin
      @(posedge clk); #1;
      if (endsignal === 1'b1) ends++;
    end
    checks++;
    if (ends !== 1) begin
      failures++;
      $display("FAIL ignore_start_ends: endsignal pulses=%0d required=1", ends);
    end
    checks++;
    if (tile_type !== 6'b001101) begin
      failures++;
      $display("FAIL ignore_start_mask: tile_type=%b required=001101", tile_type);
    end
  endtask

  task automatic test_back_to_back;
    int first_end, second_end, extra;
    @(negedge clk);
    set_inputs(3'd0, 3'd5, 3'd0, 3'd0);
    start_signal = 1'b1;
    @(posedge clk); #1;
    first_end = -1; second_end = -1; extra = 0;
    for (int k = 1; k <= 22; k++) begin
      @(posedge clk); #1;
      if (k == 8) begin
        checks++;
        if (tile_type !== 6'b0) begin
          failures++;
          $display("FAIL retrigger_clear: tile_type=%b required=000000", tile_type);
        end
        start_signal = 1'b0;
      end
      if (endsignal === 1'b1) begin
        if (first_end < 0) first_end = k;
        else if (second_end < 0) second_end = k;
        else extra++;
      end
    end
    start_signal = 1'b0;
    checks++;
    if (first_end !== 7 || second_end !== 15 || extra !== 0) begin
      failures++;
      $display("FAIL retrigger_timing: ends at %0d,%0d extra=%0d required=7,15 extra=0",
               first_end, second_end, extra);
    end
    checks++;
    if (tile_type !== 6'b001110) begin
      failures++;
      $display("FAIL retrigger_mask: tile_type=%b required=001110", tile_type);
    end
  endtask

  initial begin
    test_reset;
    test_masks;
    test_all_empty;
    test_reset_midscan;
    test_start_during_scan;
    test_back_to_back;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/tile_check.md
Name: tile_check

Overview:
Legal-move checker for the Trax tile-placement engine. Given the codes of the four neighbours of an empty board cell, it finds which of the six Trax tile placements can legally go in that cell. Edge colours must match every occupied neighbour. It runs a short multi-cycle scan after a start pulse and returns a one-hot-per-candidate legality mask plus a done strobe to the move-generation controller.

Parameters:
NUM_TILES, 6, number of candidate placements scanned (fixed by the tile encoding; not to be overridden)

Ports:
clk  input  1  system clock, rising-edge active
rst  input  1  asynchronous reset, active-high
tile_type  output  6  legality mask; bit k-1 = 1 means tile code k is legal
endsignal  output  1  one-cycle done strobe
start_signal  input  1  start request, sampled on clk
up_tile  input  3  tile code of neighbour above
down_tile  input  3  tile code of neighbour below
right_tile  input  3  tile code of neighbour to the right
left_tile  input  3  tile code of neighbour to the left
Positional instantiation order: tile_type, endsignal, start_signal, up_tile, down_tile, right_tile, left_tile, clk, rst.

Behaviour:
- Tile codes give edge colours as up/down/left/right, R = red, W = white:
  - 0: empty cell; no constraint.
  - 1: cross, red vertical: R/R/W/W.
  - 2: cross, red horizontal: W/W/R/R.
  - 3: curve, red up-left: R/W/R/W.
  - 4: curve, red up-right: R/W/W/R.
  - 5: curve, red down-right: W/R/W/R.
  - 6: curve, red down-left: W/R/R/W.
  - 7: invalid; when present on any neighbour, every candidate is illegal.
- Candidate c is legal iff all of these hold:
  - at least one neighbour is non-zero;
  - no neighbour is 7;
  - for each non-empty neighbour, the facing edges match: c.up = up_tile.down, c.down = down_tile.up, c.left = left_tile.right, c.right = right_tile.left.
- All neighbours empty -> tile_type = 0 (isolated placement not allowed).
- FSM states: IDLE, SCAN, DONE.
- IDLE:
  - start_signal = 1 at a clk edge -> latch all four neighbour codes into internal registers, clear the mask, set candidate index to 1, go to SCAN.
  - Neighbour inputs are ignored after latching.
- SCAN:
  - Each cycle evaluates exactly one candidate (the index) and writes its bit; index increments.
  - After candidate 6 is written -> DONE.
- DONE:
  - endsignal = 1 for exactly one cycle, then -> IDLE.
- Latency: start sampled at edge N; mask is final and endsignal is high in the cycle after edge N+7.
- tile_type holds its value until the next accepted start; it is cleared to 0 at that start.
- start_signal while in SCAN or DONE is ignored; no queuing.
- start held high in IDLE right after DONE -> a new scan begins (re-trigger allowed).
- Reset, at any time including mid-scan:
  - tile_type = 0, endsignal = 0, state = IDLE, index = 1, latched neighbours = 0;
  - no endsignal is produced for the aborted scan.

Optional Feature:
Macro TILE_CHECK_FIRST_MOVE_EN.
- Defined: when all four latched neighbours are 0, every candidate is legal, so the scan yields tile_type = 6'b111111. This supports the opening move.
- Not defined: the all-empty case yields 6'b000000 as specified above.
- Timing and handshake are identical in both builds.

Test Plan:
- Reset asserted mid-scan -> tile_type = 0, endsignal = 0, returns to IDLE; a later start works normally.
- up = 1, others 0, start pulse -> after 8 cycles endsignal pulses once, tile_type = 6'b001101 (codes 1, 3, 4).
- up = 1, down = 2, left = right = 0, start -> tile_type = 6'b001100 (codes 3, 4).
- left = 3, right = 6, up = down = 0, start -> tile_type = 6'b011000 (codes 4, 5).
- All neighbours 0, start -> tile_type = 6'b000000; rebuild with TILE_CHECK_FIRST_MOVE_EN -> 6'b111111.
- up = 7, start -> tile_type = 0. Separately: change inputs and pulse start again during SCAN -> result reflects the first latched inputs, exactly one endsignal.
